pkt_capture_buffer: RTL and testbench

//  In-fabric packet capture for the MAC receive stream; generalises the ILA probe tap.

---
 rtl/mac_cap_pkg.sv | 29 ++
 rtl/cap_ram.sv | 38 +++
 rtl/pkt_capture_buffer.sv | 132 +++++++++++++
 tb/tb_pkt_capture_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_cap_pkg.sv
// Shared types for the MAC receive-stream capture buffer.
package mac_cap_pkg;

    // Encoding is visible on the cap_state port, so values are pinned.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } cap_state_e;

    localparam int unsigned CapDataW = 8;

    // Sideband bits stored above the data in every RAM entry.
    typedef struct packed {
        logic err;
        logic eop;
        logic sop;
    } cap_side_t;

    // Full entry layout for the default data width.
    typedef struct packed {
        logic                err;
        logic                eop;
        logic                sop;
        logic [CapDataW-1:0] data;
    } cap_entry_t;

endpackage

// File: rtl/cap_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module cap_ram #(
    parameter int unsigned WIDTH  = 11,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port; contents are never cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; only the output register is reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_capture_buffer.sv
// Packet capture buffer: arms on command, triggers on the next sop beat and
// stores beats until full, packet limit or (optionally) the first errored packet.
module pkt_capture_buffer
    import mac_cap_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                mac_clk,
    input  logic                mac_rst,
    input  logic                startofpacket,
    input  logic                endofpacket,
    input  logic                valid,
    input  logic [DATA_W-1:0]   data,
    input  logic                error,
    input  logic                arm,
    input  logic                abort,
    input  logic                stop_on_err,
    input  logic [CNT_W-1:0]    pkt_limit,
    output logic [1:0]          cap_state,
    output logic                done,
    output logic                truncated,
    output logic [ADDR_W:0]     wr_count,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W+2:0]   rd_data
);

    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    cap_state_e          state_q;
    logic                truncated_q;
    logic [ADDR_W:0]     wr_count_q;
    logic [CNT_W-1:0]    pkt_cnt_q;
    logic [CNT_W-1:0]    err_cnt_q;

    logic                wr_en;
    logic                last_slot;
    logic                limit_hit;
    logic                stop;
    logic [CNT_W-1:0]    pkt_cnt_inc;
    logic [CNT_W-1:0]    err_cnt_inc;
    logic [ADDR_W:0]     wr_count_inc;
    cap_side_t           side;
    logic [DATA_W+2:0]   wdata;

    // Write qualification, stop conditions and saturating increments.
    always_comb begin
        wr_en = valid && !mac_rst && !abort &&
                ((state_q == StCapture) || ((state_q == StArmed) && startofpacket));
        wr_count_inc = wr_count_q + (ADDR_W + 1)'(1);
        last_slot    = (wr_count_inc == FullCount);
        // Compare one bit wider so pkt_cnt_q == max cannot alias a small limit.
        limit_hit    = (pkt_limit != '0) &&
                       (({1'b0, pkt_cnt_q} + (CNT_W + 1)'(1)) == {1'b0, pkt_limit});
        stop         = last_slot ||
                       (endofpacket && (limit_hit || (stop_on_err && error)));
        pkt_cnt_inc  = (pkt_cnt_q == '1) ? pkt_cnt_q : pkt_cnt_q + CNT_W'(1);
        err_cnt_inc  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);
        side.err     = error;
        side.eop     = endofpacket;
        side.sop     = startofpacket;
        wdata        = {side, data};
    end

    // Capture FSM with write pointer, counters and truncation flag.
    always_ff @(posedge mac_clk) begin
        if (mac_rst) begin
            state_q     <= StIdle;
            truncated_q <= 1'b0;
            wr_count_q  <= '0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else if (abort) begin
            // Counters deliberately held so an aborted capture can be inspected.
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        state_q     <= StArmed;
                        truncated_q <= 1'b0;
                        wr_count_q  <= '0;
                        pkt_cnt_q   <= '0;
                        err_cnt_q   <= '0;
                    end
                end
                StArmed, StCapture: begin
                    if (wr_en) begin
                        wr_count_q <= wr_count_inc;
                        if (endofpacket) begin
                            pkt_cnt_q <= pkt_cnt_inc;
                            if (error) begin
                                err_cnt_q <= err_cnt_inc;
                            end
                        end
                        if (last_slot && !endofpacket) begin
                            truncated_q <= 1'b1;
                        end
                        state_q <= stop ? StDone : StCapture;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    cap_ram #(
        .WIDTH  (DATA_W + 3),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (mac_clk),
        .rst_i   (mac_rst),
        .we_i    (wr_en),
        .waddr_i (wr_count_q[ADDR_W-1:0]),
        .wdata_i (wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign cap_state = state_q;
    assign done      = (state_q == StDone);
    assign truncated = truncated_q;
    assign wr_count  = wr_count_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pkt_capture_buffer.sv
// Directed bench: a 256-entry and a 16-entry instance share one stimulus stream.
module tb_pkt_capture_buffer;

    logic        mac_clk = 1'b0;
    logic        mac_rst;
    logic        startofpacket, endofpacket, valid, error;
    logic [7:0]  data;
    logic        arm, abort, stop_on_err;
    logic [15:0] pkt_limit;
    logic [7:0]  rd_addr;

    logic [1:0]  b_state, s_state;
    logic        b_done, s_done, b_trunc, s_trunc;
    logic [8:0]  b_wr_count;
    logic [4:0]  s_wr_count;
    logic [15:0] b_pkt_cnt, s_pkt_cnt, b_err_cnt, s_err_cnt;
    logic [10:0] b_rd_data, s_rd_data;

    int checks = 0;
    int errors = 0;

    always #5 mac_clk = ~mac_clk;

    pkt_capture_buffer #(.DATA_W(8), .DEPTH(256), .CNT_W(16)) u_big (
        .mac_clk(mac_clk), .mac_rst(mac_rst), .startofpacket(startofpacket),
        .endofpacket(endofpacket), .valid(valid), .data(data), .error(error),
        .arm(arm), .abort(abort), .stop_on_err(stop_on_err), .pkt_limit(pkt_limit),
        .cap_state(b_state), .done(b_done), .truncated(b_trunc), .wr_count(b_wr_count),
        .pkt_cnt(b_pkt_cnt), .err_cnt(b_err_cnt), .rd_addr(rd_addr), .rd_data(b_rd_data)
    );

    pkt_capture_buffer #(.DATA_W(8), .DEPTH(16), .CNT_W(16)) u_small (
        .mac_clk(mac_clk), .mac_rst(mac_rst), .startofpacket(startofpacket),
        .endofpacket(endofpacket), .valid(valid), .data(data), .error(error),
        .arm(arm), .abort(abort), .stop_on_err(stop_on_err), .pkt_limit(pkt_limit),
        .cap_state(s_state), .done(s_done), .truncated(s_trunc), .wr_count(s_wr_count),
        .pkt_cnt(s_pkt_cnt), .err_cnt(s_err_cnt), .rd_addr(rd_addr[3:0]),
        .rd_data(s_rd_data)
    );

    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic [10:0] exp;
    } rb_t;

    rb_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mac_clk);
        #1;
    endtask

    task automatic beat(input logic s, input logic e, input logic er, input logic [7:0] d);
        valid = 1'b1; startofpacket = s; endofpacket = e; error = er; data = d;
        tick();
        valid = 1'b0; startofpacket = 1'b0; endofpacket = 1'b0; error = 1'b0; data = 8'h00;
    endtask

    task automatic pkt(input int len, input logic [7:0] base, input logic er);
        for (int i = 0; i < len; i++) begin
            beat(i == 0, i == len - 1, er && (i == len - 1), base + 8'(i));
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"lim_rd0",   8'd0,   11'h100};
        tbl[1] = '{"lim_rd1",   8'd1,   11'h001};
        tbl[2] = '{"lim_rd63",  8'd63,  11'h23F};
        tbl[3] = '{"lim_rd64",  8'd64,  11'h140};
        tbl[4] = '{"lim_rd100", 8'd100, 11'h064};
        tbl[5] = '{"lim_rd127", 8'd127, 11'h27F};

        mac_rst = 1'b1; valid = 1'b0; startofpacket = 1'b0; endofpacket = 1'b0;
        error = 1'b0; data = 8'h00; arm = 1'b0; abort = 1'b0; stop_on_err = 1'b0;
        pkt_limit = 16'd0; rd_addr = 8'd0;
        tick(); tick();
        chk("rst_state", b_state, 0);
        chk("rst_done", b_done, 0);
        chk("rst_trunc", b_trunc, 0);
        chk("rst_wr_count", b_wr_count, 0);
        chk("rst_pkt_cnt", b_pkt_cnt, 0);
        chk("rst_err_cnt", b_err_cnt, 0);
        chk("rst_rd_data", b_rd_data, 0);
        mac_rst = 1'b0;
        tick();

        // Packet limit of 2 with three 64-byte packets.
        pkt_limit = 16'd2;
        pulse_arm();
        chk("lim_armed", b_state, 1);
        pkt(64, 8'h00, 1'b0);
        chk("lim_mid_state", b_state, 2);
        pkt(64, 8'h40, 1'b0);
        chk("lim_state", b_state, 3);
        chk("lim_done", b_done, 1);
        chk("lim_wr_count", b_wr_count, 128);
        chk("lim_pkt_cnt", b_pkt_cnt, 2);
        pkt(64, 8'h80, 1'b0);
        chk("lim_3rd_ignored", b_wr_count, 128);
        chk("lim_3rd_pkt_cnt", b_pkt_cnt, 2);
        for (int i = 0; i < 6; i++) begin
            rd_addr = tbl[i].addr;
            tick();
            chk(tbl[i].name, b_rd_data, tbl[i].exp);
        end

        // Arm while the stream is mid-packet: tail must be discarded.
        pulse_abort();
        pkt_limit = 16'd0;
        pulse_arm();
        beat(1'b0, 1'b0, 1'b0, 8'hA0);
        beat(1'b0, 1'b0, 1'b0, 8'hA1);
        beat(1'b0, 1'b1, 1'b0, 8'hA2);
        chk("mid_still_armed", b_state, 1);
        chk("mid_no_writes", b_wr_count, 0);
        chk("mid_no_pkts", b_pkt_cnt, 0);
        pkt(10, 8'h10, 1'b0);
        chk("mid_state", b_state, 2);
        chk("mid_wr_count", b_wr_count, 10);
        chk("mid_pkt_cnt", b_pkt_cnt, 1);
        rd_addr = 8'd0; tick();
        chk("mid_rd0", b_rd_data, 11'h110);
        rd_addr = 8'd9; tick();
        chk("mid_rd9", b_rd_data, 11'h219);

        // Small instance: overflow truncates, exact fit does not.
        pulse_abort();
        pulse_arm();
        pkt(20, 8'h30, 1'b0);
        chk("full_state", s_state, 3);
        chk("full_wr_count", s_wr_count, 16);
        chk("full_trunc", s_trunc, 1);
        chk("full_pkt_cnt", s_pkt_cnt, 0);
        chk("full_big_continues", b_wr_count, 20);
        pulse_abort();
        pulse_arm();
        chk("rearm_trunc_clr", s_trunc, 0);
        pkt(16, 8'h40, 1'b0);
        chk("exact_state", s_state, 3);
        chk("exact_wr_count", s_wr_count, 16);
        chk("exact_trunc", s_trunc, 0);
        chk("exact_pkt_cnt", s_pkt_cnt, 1);
        rd_addr = 8'd15; tick();
        chk("exact_rd15", s_rd_data, 11'h24F);
        rd_addr = 8'd0; tick();
        chk("exact_rd0", s_rd_data, 11'h140);

        // Stop on first errored packet.
        pulse_abort();
        stop_on_err = 1'b1;
        pulse_arm();
        pkt(4, 8'h50, 1'b0);
        chk("err_first_open", b_state, 2);
        pkt(4, 8'h54, 1'b1);
        chk("err_state", b_state, 3);
        chk("err_err_cnt", b_err_cnt, 1);
        chk("err_pkt_cnt", b_pkt_cnt, 2);
        chk("err_wr_count", b_wr_count, 8);
        pkt(4, 8'h58, 1'b0);
        chk("err_after_done", b_wr_count, 8);
        rd_addr = 8'd7; tick();
        chk("err_rd7", b_rd_data, 11'h657);
        stop_on_err = 1'b0;

        // Valid gaps with garbage sideband on idle cycles.
        pulse_abort();
        pulse_arm();
        for (int i = 0; i < 8; i++) begin
            beat(i == 0, i == 7, 1'b0, 8'h60 + 8'(i));
            startofpacket = 1'b1; endofpacket = 1'b1; error = 1'b1; data = 8'hFF;
            tick();
            startofpacket = 1'b0; endofpacket = 1'b0; error = 1'b0; data = 8'h00;
        end
        chk("gap_wr_count", b_wr_count, 8);
        chk("gap_pkt_cnt", b_pkt_cnt, 1);
        chk("gap_err_cnt", b_err_cnt, 0);
        rd_addr = 8'd0; tick();
        chk("gap_rd0", b_rd_data, 11'h160);
        rd_addr = 8'd3; tick();
        chk("gap_rd3", b_rd_data, 11'h063);
        rd_addr = 8'd7; #1;
        chk("gap_rd_latency", b_rd_data, 11'h063);
        tick();
        chk("gap_rd7", b_rd_data, 11'h267);

        // abort and arm together in CAPTURE: abort wins, counters hold.
        pulse_abort();
        pulse_arm();
        beat(1'b1, 1'b0, 1'b0, 8'h70);
        beat(1'b0, 1'b0, 1'b0, 8'h71);
        beat(1'b0, 1'b0, 1'b0, 8'h72);
        chk("ab_capture", b_state, 2);
        abort = 1'b1; arm = 1'b1;
        tick();
        abort = 1'b0; arm = 1'b0;
        chk("ab_idle", b_state, 0);
        chk("ab_hold_wr", b_wr_count, 3);
        beat(1'b1, 1'b1, 1'b0, 8'h73);
        chk("idle_ignores_beat", b_wr_count, 3);
        chk("idle_ignores_eop", b_pkt_cnt, 0);

        // Reset mid-capture with the small instance truncated.
        pulse_arm();
        pkt(20, 8'h90, 1'b1);
        chk("pre_rst_trunc", s_trunc, 1);
        chk("pre_rst_err", b_err_cnt, 1);
        rd_addr = 8'd0; tick();
        chk("pre_rst_rd0", b_rd_data, 11'h190);
        beat(1'b1, 1'b0, 1'b0, 8'hB0);
        mac_rst = 1'b1;
        tick();
        chk("mrst_state", b_state, 0);
        chk("mrst_wr_count", b_wr_count, 0);
        chk("mrst_pkt_cnt", b_pkt_cnt, 0);
        chk("mrst_err_cnt", b_err_cnt, 0);
        chk("mrst_rd_data", b_rd_data, 0);
        chk("mrst_s_done", s_done, 0);
        chk("mrst_s_trunc", s_trunc, 0);
        chk("mrst_s_state", s_state, 0);
        mac_rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
